adc_sample_fifo: RTL and testbench
==================================

ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entries; power of two, range 4..1024.
REQ-002 SHALL derive localparam AW = log2(DEPTH), pointer/address width.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level; 1 = accept incoming samples.
REQ-006 SHALL have port sample_data  input  32  ADC sample word from ADC manager.
REQ-007 SHALL have port sample_valid  input  1  single-cycle strobe; no backpressure possible.
REQ-008 SHALL have port m_axis_data_tdata  output  32  AXI-Stream data to packetizer.
REQ-009 SHALL have port m_axis_data_tvalid  output  1  AXI-Stream valid.
REQ-010 SHALL have port m_axis_data_tready  input  1  AXI-Stream ready from packetizer.
REQ-011 SHALL have port clear_overflow  input  1  single-cycle pulse; clears overflow status.
REQ-012 SHALL have port overflow  output  1  sticky flag; at least one sample dropped.
REQ-013 SHALL have port overflow_count  output  16  saturating count of dropped samples.
REQ-014 SHALL have port fill_level  output  AW+1  current number of stored entries.

Function
REQ-015 SHALL store samples in a DEPTH x 32 circular buffer with AW-bit write/read pointers wrapping DEPTH-1 -> 0.
REQ-016 SHALL define write = sample_valid & enable & (not full | read); read = m_axis_data_tvalid & m_axis_data_tready.
REQ-017 SHALL define full = (fill_level == DEPTH), empty = (fill_level == 0).
REQ-018 SHALL on write store sample_data at write pointer and increment write pointer at the same edge.
REQ-019 SHALL on read increment read pointer at the edge where tvalid & tready are both high.
REQ-020 SHALL update fill_level: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 SHALL drive m_axis_data_tvalid = not empty, first-word-fall-through; tdata = entry at read pointer.
REQ-022 SHALL give latency of one cycle: sample strobed at edge N into an empty FIFO yields tvalid=1 and tdata = that sample during cycle N+1.
REQ-023 SHALL hold tdata and tvalid stable while tvalid=1 and tready=0 (AXI-Stream rule); no tvalid deassertion without a transfer.
REQ-024 SHALL accept a write when full if a read occurs in the same cycle; fill_level stays DEPTH.
REQ-025 SHALL drop a sample when sample_valid & enable & full & no read: no storage, pointers unchanged.
REQ-026 SHALL on each dropped sample set overflow=1 and increment overflow_count, saturating at 16'hFFFF.
REQ-027 SHALL ignore samples while enable=0; they SHALL NOT count as overflow; stored entries continue to drain.
REQ-028 SHALL on clear_overflow clear overflow and overflow_count; a simultaneous drop SHALL leave overflow=1, overflow_count=1.
REQ-029 SHALL not alter FIFO contents, pointers or fill_level on clear_overflow.

Reset
REQ-030 SHALL on areset=1 immediately clear pointers and fill_level to 0, tvalid to 0, overflow to 0, overflow_count to 0, independent of aclk.
REQ-031 SHALL discard all stored entries on reset, including mid-transfer; memory contents need not be cleared.
REQ-032 SHALL ignore sample_valid and tready while areset=1; normal operation from first rising edge after deassertion.

Verification
REQ-033 Basic flow: DEPTH=16, enable=1, tready=1, strobe samples 0x0000_0001..0x0000_0005 on alternate cycles -> same five words out in order, each 1 cycle after strobe, fill_level never above 1.
REQ-034 Backpressure/fill: tready=0, strobe 16 samples -> fill_level=16, tvalid=1, tdata=first sample held stable; tready=1 -> 16 words drained in order, fill_level 0, tvalid 0.
REQ-035 Overflow: FIFO full, tready=0, strobe 3 more -> overflow=1, overflow_count=3, stored data unchanged; pulse clear_overflow -> 0/0.
REQ-036 Full with simultaneous read/write: fill_level=16, tready=1 and strobe same cycle -> sample accepted, fill_level=16, overflow_count unchanged.
REQ-037 Enable gating and saturation: enable=0 with 10 strobes -> fill_level 0, overflow_count 0; force 65540 drops -> overflow_count=16'hFFFF.
REQ-038 Reset mid-operation: fill_level=7, assert areset between edges -> tvalid, fill_level, overflow drop to 0 without clock edge; after release first strobed sample is first output.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: first-word-fall-through sample FIFO from the ADC manager to an AXI-Stream packetizer.
// Samples arriving while full with no read are dropped and counted in a sticky, saturating overflow counter.
module adc_sample_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          enable,
    input  logic [31:0]   sample_data,
    input  logic          sample_valid,
    output logic [31:0]   m_axis_data_tdata,
    output logic          m_axis_data_tvalid,
    input  logic          m_axis_data_tready,
    input  logic          clear_overflow,
    output logic          overflow,
    output logic [15:0]   overflow_count,
    output logic [AW:0]   fill_level
);
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          r_ovf;
    logic [15:0]   r_ovf_cnt;
    logic          w_full;
    logic          w_empty;
    logic          w_rd;
    logic          w_wr;
    logic          w_drop;

    assign w_full  = r_fill == (AW+1)'(DEPTH);
    assign w_empty = r_fill == '0;
    assign w_rd    = ~w_empty & m_axis_data_tready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_wr    = sample_valid & enable & (~w_full | w_rd);
    assign w_drop  = sample_valid & enable & w_full & ~w_rd;

    assign m_axis_data_tdata  = r_mem[r_rd_ptr];
    assign m_axis_data_tvalid = ~w_empty;
    assign overflow           = r_ovf;
    assign overflow_count     = r_ovf_cnt;
    assign fill_level         = r_fill;

    // Storage is deliberately not reset; the cleared fill level hides stale entries.
    always_ff @(posedge aclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= sample_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr != w_rd) r_fill <= w_wr ? r_fill + (AW+1)'(1) : r_fill - (AW+1)'(1);
            // A drop coinciding with a clear survives as a single counted drop.
            if (clear_overflow) begin
                r_ovf     <= w_drop;
                r_ovf_cnt <= {15'd0, w_drop};
            end else if (w_drop) begin
                r_ovf     <= 1'b1;
                r_ovf_cnt <= (r_ovf_cnt == 16'hFFFF) ? r_ovf_cnt : r_ovf_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: scoreboard bench for adc_sample_fifo against a queue/counter reference model.
// Directed scenarios for flow, backpressure, overflow, saturation and async reset, then random traffic.
module tb_adc_sample_fifo;
    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b0;
    logic [31:0]   sample_data = '0;
    logic          sample_valid = 1'b0;
    logic [31:0]   m_axis_data_tdata;
    logic          m_axis_data_tvalid;
    logic          m_axis_data_tready = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          overflow;
    logic [15:0]   overflow_count;
    logic [AW:0]   fill_level;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    int          m_fill = 0;
    bit          m_ovf = 0;
    int          m_cnt = 0;

    adc_sample_fifo #(.DEPTH(DEPTH)) dut (
        .aclk(aclk),
        .areset(areset),
        .enable(enable),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .m_axis_data_tdata(m_axis_data_tdata),
        .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tready(m_axis_data_tready),
        .clear_overflow(clear_overflow),
        .overflow(overflow),
        .overflow_count(overflow_count),
        .fill_level(fill_level)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy counter, expected-data queue and drop bookkeeping.
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_fill = 0;
            m_ovf  = 0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            bit rd, acc, wr, drop;
            rd   = (m_fill > 0) && m_axis_data_tready;
            acc  = sample_valid && enable;
            wr   = acc && (m_fill < DEPTH || rd);
            drop = acc && !wr;
            m_fill = m_fill + int'(wr) - int'(rd);
            if (wr) exp_q.push_back(sample_data);
            if (clear_overflow) begin
                m_ovf = drop;
                m_cnt = int'(drop);
            end else if (drop) begin
                m_ovf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    // Monitor: compares visible outputs half a cycle after every edge.
    always @(negedge aclk) begin
        if (!areset) begin
            chk("tvalid", m_axis_data_tvalid, m_fill != 0);
            chk("fill_level", fill_level, m_fill);
            chk("overflow", overflow, m_ovf);
            chk("overflow_count", overflow_count, m_cnt);
            if (m_axis_data_tvalid) begin
                if (exp_q.size() == 0) chk("data_available", 0, 1);
                else begin
                    chk("tdata", m_axis_data_tdata, exp_q[0]);
                    if (m_axis_data_tready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic sv, input logic [31:0] d, input logic en, input logic rdy, input logic clr);
        @(posedge aclk);
        #1;
        sample_valid = sv;
        sample_data = d;
        enable = en;
        m_axis_data_tready = rdy;
        clear_overflow = clr;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH; i++) cyc(0, 0, 1, 1, 0);
        chk("drained", fill_level, 0);
    endtask

    initial begin
        #3;
        chk("reset_tvalid", m_axis_data_tvalid, 0);
        chk("reset_fill", fill_level, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_count", overflow_count, 0);
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            cyc(1, 32'(i), 1, 1, 0);
            cyc(0, 0, 1, 1, 0);
        end
        drain();

        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h100 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("drain_empty", m_axis_data_tvalid, 0);

        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h200 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'hDEAD0000 + 32'(i), 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("overflow_three", overflow_count, 3);
        cyc(0, 0, 1, 0, 1);
        cyc(1, 32'h300, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("full_rw_fill", fill_level, DEPTH);
        chk("full_rw_count", overflow_count, 0);
        drain();

        for (int i = 0; i < 10; i++) cyc(1, 32'h400 + 32'(i), 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("disabled_fill", fill_level, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h500 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 65540; i++) cyc(1, 32'(i), 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("saturated", overflow_count, 16'hFFFF);
        cyc(1, 32'h600, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        chk("clear_with_drop", overflow_count, 1);
        cyc(0, 0, 1, 0, 1);
        drain();

        for (int i = 0; i < 7; i++) cyc(1, 32'h700 + 32'(i), 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("async_tvalid", m_axis_data_tvalid, 0);
        chk("async_fill", fill_level, 0);
        chk("async_overflow", overflow, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        cyc(1, 32'hCAFE0001, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("post_reset_head", m_axis_data_tdata, 32'hCAFE0001);
        drain();

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
